// File: rtl/apb_protocol_monitor.sv
// apb_protocol_monitor: passive observer for one APB master bus.
// It flags protocol violations (X/Z values, phase order, one-hot select,
// signal stability, wait-state timeout). It also reports each completed
// transfer together with its attributes and the number of wait states.
//
// state  | meaning
// IDLE   | no transfer open; waiting for a SETUP sample
// ACCESS | SETUP seen and latched; waiting for a completing ACCESS sample
module apb_protocol_monitor #(
  parameter int PADDR_WIDTH    = 32,
  parameter int PWDATA_WIDTH   = 32,
  parameter int PRDATA_WIDTH   = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8,
  localparam int XDATA_WIDTH   = (PWDATA_WIDTH > PRDATA_WIDTH) ? PWDATA_WIDTH : PRDATA_WIDTH,
  localparam int WAIT_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic                    prwd,
  input  logic [PWDATA_WIDTH-1:0] pwdata,
  input  logic                    penable,
  input  logic                    pready,
  input  logic [PRDATA_WIDTH-1:0] prdata,
  input  logic                    pslverr,
  input  logic [NUM_SLAVES-1:0]   psel,
  input  logic                    has_checks,
  input  logic                    clear_err,
  output logic                    err_valid,
  output logic [3:0]              err_code,
  output logic [3:0]              first_err_code,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    xfer_done,
  output logic                    xfer_write,
  output logic [PADDR_WIDTH-1:0]  xfer_addr,
  output logic [XDATA_WIDTH-1:0]  xfer_data,
  output logic                    xfer_slverr,
  output logic [4:0]              xfer_slave,
  output logic [WAIT_WIDTH-1:0]   xfer_waits
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PADDR_WIDTH-1:0]  lat_addr;
  logic                    lat_write;
  logic [PWDATA_WIDTH-1:0] lat_wdata;
  logic [NUM_SLAVES-1:0]   lat_sel;
  logic [WAIT_WIDTH-1:0]   wait_q;
  logic [WAIT_WIDTH-1:0]   wait_inc;

  logic        sel_any, setup_seen, access_seen;
  logic        in_access, complete, wait_hit, mismatch;
  logic [11:1] viol;
  logic [3:0]  viol_code;
  logic [4:0]  slave_idx;

  logic                 err_valid_d;
  logic [3:0]           err_code_d;
  logic [3:0]           first_d;
  logic [CNT_WIDTH-1:0] err_count_d;
  logic [XDATA_WIDTH-1:0] xfer_data_d;

  assign sel_any     = |psel;
  assign setup_seen  = sel_any & ~penable;
  assign access_seen = sel_any & penable;
  assign in_access   = (state_q == S_ACCESS);
  assign wait_inc    = wait_q + WAIT_WIDTH'(1);
  assign wait_hit    = (wait_inc == WAIT_WIDTH'(TIMEOUT_CYCLES));
  assign complete    = in_access & access_seen & pready;
  assign mismatch    = (paddr != lat_addr) || (prwd != lat_write) || (psel != lat_sel) ||
                       (prwd && (pwdata != lat_wdata));

  // Collect every violation present in this sample, one bit per code.
  always_comb begin
    viol = '0;
`ifndef SYNTHESIS
    viol[1]  = sel_any && $isunknown(paddr);
    viol[2]  = sel_any && $isunknown(prwd);
    viol[3]  = sel_any && (prwd == 1'b1) && $isunknown(pwdata);
    viol[4]  = $isunknown(penable);
    viol[5]  = $isunknown(psel);
    viol[11] = complete && !lat_write && $isunknown(prdata);
`endif
    viol[6]  = (psel & (psel - NUM_SLAVES'(1))) != '0;
    viol[7]  = !in_access && access_seen;
    viol[8]  = in_access && !access_seen;
    viol[9]  = in_access && access_seen && mismatch;
    viol[10] = in_access && access_seen && !pready && wait_hit;
  end

  // Lowest-numbered violation wins; scanning downward leaves it last.
  always_comb begin
    viol_code = 4'd0;
    for (int i = 11; i >= 1; i--) begin
      if (viol[i]) viol_code = 4'(i);
    end
  end

  // Index of the lowest set bit of the latched select.
  always_comb begin
    slave_idx = 5'd0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (lat_sel[i]) slave_idx = 5'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (setup_seen) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (access_seen) begin
          if (pready || wait_hit) state_d = S_IDLE;
        end else if (setup_seen) begin
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    err_valid_d = has_checks && (viol != '0);
    err_code_d  = err_valid_d ? viol_code : 4'd0;
    err_count_d = err_count;
    first_d     = first_err_code;
    if (clear_err) begin
      err_count_d = err_valid_d ? CNT_WIDTH'(1) : '0;
      first_d     = err_valid_d ? viol_code : 4'd0;
    end else if (err_valid_d) begin
      if (err_count != '1) err_count_d = err_count + CNT_WIDTH'(1);
      if (first_err_code == 4'd0) first_d = viol_code;
    end
    xfer_data_d = lat_write ? XDATA_WIDTH'(lat_wdata) : XDATA_WIDTH'(prdata);
  end

  // SETUP latch and wait-state counter; a new SETUP always relatches.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_sel   <= '0;
      wait_q    <= '0;
    end else if (setup_seen) begin
      lat_addr  <= paddr;
      lat_write <= prwd;
      lat_wdata <= pwdata;
      lat_sel   <= psel;
      wait_q    <= '0;
    end else if (in_access && access_seen && !pready) begin
      wait_q    <= wait_inc;
    end
  end

  // Registered outputs; transfer attributes load only on completion.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      err_valid      <= 1'b0;
      err_code       <= 4'd0;
      first_err_code <= 4'd0;
      err_count      <= '0;
      xfer_done      <= 1'b0;
      xfer_write     <= 1'b0;
      xfer_addr      <= '0;
      xfer_data      <= '0;
      xfer_slverr    <= 1'b0;
      xfer_slave     <= 5'd0;
      xfer_waits     <= '0;
    end else begin
      err_valid      <= err_valid_d;
      err_code       <= err_code_d;
      first_err_code <= first_d;
      err_count      <= err_count_d;
      xfer_done      <= complete;
      if (complete) begin
        xfer_write  <= lat_write;
        xfer_addr   <= lat_addr;
        xfer_data   <= xfer_data_d;
        xfer_slverr <= pslverr;
        xfer_slave  <= slave_idx;
        xfer_waits  <= wait_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor: directed vector table, hand sequences for
// timeout/clear/reset corners, and random transfers against a transfer-level model.
module tb_apb_protocol_monitor;

  localparam int TO   = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic        pclock, preset;
  logic [31:0] paddr, pwdata, prdata;
  logic        prwd, penable, pready, pslverr, has_checks, clear_err;
  logic [15:0] psel;
  logic        err_valid, xfer_done, xfer_write, xfer_slverr;
  logic [3:0]  err_code, first_err_code;
  logic [7:0]  err_count;
  logic [31:0] xfer_addr, xfer_data;
  logic [4:0]  xfer_slave, xfer_waits;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic x_capable;
  logic xprobe;

  apb_protocol_monitor #(
    .PADDR_WIDTH(32), .PWDATA_WIDTH(32), .PRDATA_WIDTH(32),
    .NUM_SLAVES(16), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .pclock(pclock), .preset(preset), .paddr(paddr), .prwd(prwd), .pwdata(pwdata),
    .penable(penable), .pready(pready), .prdata(prdata), .pslverr(pslverr), .psel(psel),
    .has_checks(has_checks), .clear_err(clear_err),
    .err_valid(err_valid), .err_code(err_code), .first_err_code(first_err_code),
    .err_count(err_count), .xfer_done(xfer_done), .xfer_write(xfer_write),
    .xfer_addr(xfer_addr), .xfer_data(xfer_data), .xfer_slverr(xfer_slverr),
    .xfer_slave(xfer_slave), .xfer_waits(xfer_waits)
  );

  initial pclock = 1'b0;
  always #5 pclock = ~pclock;

  typedef struct {
    logic [15:0] psel; logic en; logic [31:0] addr; logic wr; logic [31:0] wdata;
    logic rdy; logic [31:0] rdata; logic sl; logic chk; logic clr;
    logic e_done; logic e_err; logic [3:0] e_code; int e_cnt; logic [3:0] e_first;
    logic x_wr; logic [31:0] x_addr; logic [31:0] x_data; logic x_sl; int x_slave; int x_waits;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [15:0] s, logic en, logic [31:0] a, logic w, logic [31:0] wd,
                              logic rdy, logic [31:0] rd, logic sl, logic chk, logic clr,
                              logic ed, logic ee, logic [3:0] ec, int ecnt, logic [3:0] ef,
                              logic xw, logic [31:0] xa, logic [31:0] xd, logic xs, int xsl, int xwt);
    vec_t r;
    r.psel = s; r.en = en; r.addr = a; r.wr = w; r.wdata = wd; r.rdy = rdy; r.rdata = rd;
    r.sl = sl; r.chk = chk; r.clr = clr; r.e_done = ed; r.e_err = ee; r.e_code = ec;
    r.e_cnt = ecnt; r.e_first = ef; r.x_wr = xw; r.x_addr = xa; r.x_data = xd; r.x_sl = xs;
    r.x_slave = xsl; r.x_waits = xwt;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(string tag, logic e_done, logic e_err, logic [3:0] e_code,
                           int e_cnt, logic [3:0] e_first);
    check({tag, " xfer_done"}, 64'(xfer_done), 64'(e_done));
    check({tag, " err_valid"}, 64'(err_valid), 64'(e_err));
    check({tag, " err_code"}, 64'(err_code), 64'(e_code));
    check({tag, " err_count"}, 64'(err_count), 64'(e_cnt));
    check({tag, " first_err_code"}, 64'(first_err_code), 64'(e_first));
  endtask

  task automatic check_xfer(string tag, logic w, logic [31:0] a, logic [31:0] d, logic sl,
                            int slave, int waits);
    check({tag, " xfer_write"}, 64'(xfer_write), 64'(w));
    check({tag, " xfer_addr"}, 64'(xfer_addr), 64'(a));
    check({tag, " xfer_data"}, 64'(xfer_data), 64'(d));
    check({tag, " xfer_slverr"}, 64'(xfer_slverr), 64'(sl));
    check({tag, " xfer_slave"}, 64'(xfer_slave), 64'(slave));
    check({tag, " xfer_waits"}, 64'(xfer_waits), 64'(waits));
  endtask

  task automatic drive(logic [15:0] s, logic en, logic [31:0] a, logic w, logic [31:0] wd,
                       logic rdy, logic [31:0] rd, logic sl);
    psel = s; penable = en; paddr = a; prwd = w; pwdata = wd;
    pready = rdy; prdata = rd; pslverr = sl;
  endtask

  task automatic tick();
    @(posedge pclock);
    #1;
    clear_err = 1'b0;
  endtask

  // transfer-level model state for the random phase
  int          exp_cnt, exp_first;
  int          gap, k, waits, g, nacc;
  logic        rw, rsl, bad9, bad10;
  logic [31:0] raddr, rwdata, rrdata;

  task automatic note_err(int code);
    if (exp_cnt < CMAX) exp_cnt++;
    if (exp_first == 0) exp_first = code;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    xprobe = 1'bx;
    x_capable = $isunknown(xprobe);

    preset = 1'b0; has_checks = 1'b1; clear_err = 1'b0;
    drive(16'h0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check_out("reset", 0, 0, 0, 0, 0);
    check_xfer("reset", 0, 0, 0, 0, 0, 0);
    preset = 1'b1;

    // ---------------- directed vector table ----------------
    vecs.push_back(mk(16'h0000,0,32'h0,  0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0004,0,32'h100,1,32'hDEADBEEF,0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0004,1,32'h100,1,32'hDEADBEEF,1,32'h0,       0, 1,0, 1,0,0,0,0, 1,32'h100,32'hDEADBEEF,0,2,0));
    vecs.push_back(mk(16'h0010,0,32'h200,0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0010,1,32'h200,0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0010,1,32'h200,0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0010,1,32'h200,0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0010,1,32'h200,0,32'h0,       1,32'h12345678,1, 1,0, 1,0,0,0,0, 0,32'h200,32'h12345678,1,4,3));
    vecs.push_back(mk(16'h0001,0,32'h10, 1,32'hA5,      0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0001,1,32'h10, 1,32'hA5,      1,32'hFFFF,    0, 1,0, 1,0,0,0,0, 1,32'h10,32'hA5,0,0,0));
    vecs.push_back(mk(16'h8000,0,32'h20, 0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h8000,1,32'h20, 0,32'h0,       1,32'hCAFE,    0, 1,0, 1,0,0,0,0, 0,32'h20,32'hCAFE,0,15,0));
    vecs.push_back(mk(16'h0000,0,32'h0,  0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0002,1,32'h0,  0,32'h0,       0,32'h0,       0, 1,0, 0,1,7,1,7, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0000,0,32'h0,  0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,1,7, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0002,0,32'h30, 1,32'h1,       0,32'h0,       0, 1,0, 0,0,0,1,7, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0000,0,32'h0,  0,32'h0,       0,32'h0,       0, 1,0, 0,1,8,2,7, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0002,0,32'h40, 0,32'h0,       0,32'h0,       0, 1,0, 0,0,0,2,7, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0002,0,32'h44, 0,32'h0,       0,32'h0,       0, 1,0, 0,1,8,3,7, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0002,1,32'h44, 0,32'h0,       1,32'h77,      0, 1,0, 1,0,0,3,7, 0,32'h44,32'h77,0,1,0));
    vecs.push_back(mk(16'h0001,1,32'h0,  0,32'h0,       0,32'h0,       0, 0,0, 0,0,0,3,7, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0000,0,32'h0,  0,32'h0,       0,32'h0,       0, 1,1, 0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0003,0,32'h50, 0,32'h0,       0,32'h0,       0, 1,0, 0,1,6,1,6, 0,0,0,0,0,0));
    vecs.push_back(mk(16'h0003,1,32'h50, 0,32'h0,       1,32'h99,      0, 1,0, 1,1,6,2,6, 0,32'h50,32'h99,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      has_checks = vecs[i].chk;
      clear_err  = vecs[i].clr;
      drive(vecs[i].psel, vecs[i].en, vecs[i].addr, vecs[i].wr, vecs[i].wdata,
            vecs[i].rdy, vecs[i].rdata, vecs[i].sl);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_err, vecs[i].e_code,
                vecs[i].e_cnt, vecs[i].e_first);
      if (vecs[i].e_done)
        check_xfer($sformatf("vec%0d", i), vecs[i].x_wr, vecs[i].x_addr, vecs[i].x_data,
                   vecs[i].x_sl, vecs[i].x_slave, vecs[i].x_waits);
    end
    has_checks = 1'b1;

    // ---------------- timeout, then normal transfer ----------------
    drive(16'h0, 0, 0, 0, 0, 0, 0, 0); clear_err = 1'b1; tick();
    check_out("to clear", 0, 0, 0, 0, 0);
    drive(16'h0002, 0, 32'h300, 0, 0, 0, 0, 0); tick();
    check_out("to setup", 0, 0, 0, 0, 0);
    for (int j = 0; j < TO; j++) begin
      drive(16'h0002, 1, 32'h300, 0, 0, 0, 32'h5, 0); tick();
      if (j == TO - 1) check_out("to expire", 0, 1, 10, 1, 10);
      else             check_out($sformatf("to wait%0d", j), 0, 0, 0, 0, 0);
    end
    drive(16'h0002, 0, 32'h304, 0, 0, 0, 0, 0); tick();
    check_out("to next setup", 0, 0, 0, 1, 10);
    drive(16'h0002, 1, 32'h304, 0, 0, 1, 32'hABCD, 0); tick();
    check_out("to next done", 1, 0, 0, 1, 10);
    check_xfer("to next", 0, 32'h304, 32'hABCD, 0, 1, 0);

    // ---------------- multi-select, clear, unstable address ----------------
    drive(16'h0005, 0, 32'h100, 1, 32'h11, 0, 0, 0); tick();
    check_out("sel5 setup", 0, 1, 6, 2, 10);
    drive(16'h0005, 1, 32'h100, 1, 32'h11, 1, 0, 0); clear_err = 1'b1; tick();
    check_out("sel5 access+clr", 1, 1, 6, 1, 6);
    check_xfer("sel5", 1, 32'h100, 32'h11, 0, 0, 0);
    drive(16'h0, 0, 0, 0, 0, 0, 0, 0); tick();
    check_out("sel5 idle", 0, 0, 0, 1, 6);
    drive(16'h0001, 0, 32'h100, 1, 32'h22, 0, 0, 0); tick();
    check_out("unstable setup", 0, 0, 0, 1, 6);
    drive(16'h0001, 1, 32'h104, 1, 32'h22, 1, 0, 0); tick();
    check_out("unstable access", 1, 1, 9, 2, 6);
    check_xfer("unstable", 1, 32'h100, 32'h22, 0, 0, 0);

    // ---------------- X on penable, checks off/on, clear with violation ----------------
    drive(16'h0, 0, 0, 0, 0, 0, 0, 0); penable = 1'bx; has_checks = 1'b0; tick();
    check_out("penX off", 0, 0, 0, 2, 6);
    has_checks = 1'b1; tick();
    check_out("penX on", 0, x_capable, x_capable ? 4'd4 : 4'd0, x_capable ? 3 : 2, 6);
    drive(16'h0001, 1, 0, 0, 0, 0, 0, 0); clear_err = 1'b1; tick();
    check_out("clr+code7", 0, 1, 7, 1, 7);

    // ---------------- counter saturation ----------------
    for (int i = 0; i < CMAX + 5; i++) begin
      tick();
      check($sformatf("sat cnt%0d", i), 64'(err_count), 64'((i + 2 > CMAX) ? CMAX : i + 2));
    end
    check("sat err_valid", 64'(err_valid), 64'(1));
    drive(16'h0, 0, 0, 0, 0, 0, 0, 0); tick();

    // ---------------- reset in the middle of a read ----------------
    drive(16'h0100, 0, 32'h400, 0, 0, 0, 0, 0); tick();
    drive(16'h0100, 1, 32'h400, 0, 0, 0, 32'h33, 0); tick();
    check_out("rst pre", 0, 0, 0, CMAX, 7);
    #2 preset = 1'b0;
    #1;
    check_out("rst async", 0, 0, 0, 0, 0);
    check_xfer("rst async", 0, 0, 0, 0, 0, 0);
    drive(16'h0100, 1, 32'h400, 0, 0, 1, 32'h33, 1); tick();
    check_out("rst held", 0, 0, 0, 0, 0);
    drive(16'h0, 0, 0, 0, 0, 0, 0, 0); preset = 1'b1; tick();
    check_out("rst released", 0, 0, 0, 0, 0);
    drive(16'h0040, 0, 32'h200, 1, 32'h55, 0, 0, 0); tick();
    check_out("post-rst setup", 0, 0, 0, 0, 0);
    drive(16'h0040, 1, 32'h200, 1, 32'h55, 1, 0, 0); tick();
    check_out("post-rst done", 1, 0, 0, 0, 0);
    check_xfer("post-rst", 1, 32'h200, 32'h55, 0, 6, 0);

    // ---------------- random transfers vs transfer-level model ----------------
    exp_cnt = 0; exp_first = 0;
    for (int t = 0; t < 150; t++) begin
      gap = int'($urandom_range(2, 0));
      for (int i = 0; i < gap; i++) begin
        drive(16'h0, 0, $urandom, 0, $urandom, 0, $urandom, 0); tick();
        check_out("rnd idle", 0, 0, 0, exp_cnt, 4'(exp_first));
      end
      k      = int'($urandom_range(15, 0));
      rw     = 1'($urandom_range(1, 0));
      raddr  = $urandom;
      rwdata = $urandom;
      waits  = int'($urandom_range(TO + 2, 0));
      nacc   = (waits < TO) ? waits + 1 : TO;
      g      = ($urandom_range(7, 0) == 0) ? int'($urandom_range(nacc - 1, 0)) : -1;
      drive(16'(1) << k, 0, raddr, rw, rwdata, 0, $urandom, 0); tick();
      check_out("rnd setup", 0, 0, 0, exp_cnt, 4'(exp_first));
      for (int j = 0; j < nacc; j++) begin
        rrdata = $urandom;
        rsl    = 1'($urandom_range(1, 0));
        drive(16'(1) << k, 1, (j == g) ? (raddr ^ 32'h4) : raddr, rw, rwdata,
              (j == waits), rrdata, rsl);
        tick();
        bad9  = (j == g);
        bad10 = (waits >= TO) && (j == TO - 1);
        if (bad9) note_err(9);
        else if (bad10) note_err(10);
        check_out($sformatf("rnd t%0d a%0d", t, j), (j == waits), bad9 | bad10,
                  bad9 ? 4'd9 : (bad10 ? 4'd10 : 4'd0), exp_cnt, 4'(exp_first));
        if (j == waits)
          check_xfer($sformatf("rnd t%0d", t), rw, raddr, rw ? rwdata : rrdata, rsl, k, waits);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_protocol_monitor.md
# apb_protocol_monitor

Synthesizable-style APB protocol monitor and transfer tracker that sits passively on one APB master bus, beside the master interface signals, with a parameterised bus width and slave-select count. It implements the PADDR/PRWD/PWDATA/PENABLE/PSEL X/Z checks as clocked RTL. It adds phase-sequencing, one-hot select, signal-stability and wait-state timeout checks. It also reports every completed transfer, with its wait count, to the UVC monitor and scoreboard.

## Interface
- PADDR_WIDTH, 32, address width
- PWDATA_WIDTH, 32, write data width
- PRDATA_WIDTH, 32, read data width
- NUM_SLAVES, 16, psel width (1..32)
- TIMEOUT_CYCLES, 16, maximum wait states before timeout (>=1)
- CNT_WIDTH, 8, error counter width
- pclock  in  1  bus clock, all sampling on rising edge
- preset  in  1  asynchronous, active-low reset
- paddr, prwd, pwdata, penable, pready, prdata, pslverr  in  per params/1  APB bus signals, monitored only
- psel  in  NUM_SLAVES  slave selects
- has_checks  in  1  1 = protocol errors reported; 0 = errors suppressed, tracking continues
- clear_err  in  1  synchronous clear of err_count and first_err_code
- err_valid  out  1  one-cycle pulse: violation at last sample
- err_code  out  4  code of highest-priority violation at last sample
- first_err_code  out  4  sticky code of first violation since reset/clear
- err_count  out  CNT_WIDTH  saturating violation count
- xfer_done  out  1  one-cycle pulse: transfer completed at last sample
- xfer_write, xfer_addr, xfer_data, xfer_slverr  out  1/PADDR/max(PWDATA,PRDATA)/1  completed transfer attributes
- xfer_slave  out  5  index of selected slave
- xfer_waits  out  $clog2(TIMEOUT_CYCLES+1)  wait states seen (pready low in ACCESS)

## Operation
- States: IDLE, ACCESS. State is updated on each rising edge from the sampled bus.
- IDLE, psel!=0 and penable=0: SETUP seen. Latch paddr, prwd, pwdata and psel, clear the wait counter, go to ACCESS.
- IDLE, psel!=0 and penable=1: code 7 (ENABLE_WITHOUT_SETUP). Stay in IDLE.
- ACCESS, psel!=0 and penable=1:
  - Compare the bus against the latch. Any difference in paddr, prwd or psel, or in pwdata when prwd=1, raises code 9 (UNSTABLE).
  - pready=1: transfer complete. Pulse xfer_done and go to IDLE.
  - pready=0: increment the wait counter. When it reaches TIMEOUT_CYCLES, raise code 10 (TIMEOUT) and go to IDLE without xfer_done.
- ACCESS, penable=0 or psel=0: code 8 (NO_ACCESS_PHASE). If psel!=0 and penable=0, treat the cycle as a new SETUP (relatch, stay in ACCESS); otherwise go to IDLE.
- Value checks, evaluated every sample:
  - code 1: paddr X/Z while psel!=0
  - code 2: prwd X/Z while psel!=0
  - code 3: pwdata X/Z while psel!=0 and prwd=1
  - code 4: penable X/Z
  - code 5: psel X/Z
  - code 6: more than one psel bit set
  - code 11: prdata X/Z at read completion
- X/Z checks use $isunknown and are simulation-only. Synthesis treats them as never firing.
- When several violations occur in one sample, err_code takes the lowest-numbered one. err_count increments by 1 per violating sample, not per violation.
- err_count saturates at all-ones.
- first_err_code is loaded only while it is 0.
- has_checks=0: err_valid stays 0 and err_count/first_err_code hold. The FSM and xfer_* outputs are unaffected.
- clear_err together with a violation in the same sample: err_count=1 and first_err_code=the new code.
- Completion attributes:
  - xfer_data is prdata for reads and the latched pwdata for writes.
  - xfer_slave is the index of the lowest set bit of the latched psel.
  - xfer_waits is the wait counter value.

## Timing
- All outputs are registered. A condition sampled at edge N is visible from edge N until edge N+1 (pulses are one cycle wide).
- Minimum transfer: SETUP at edge N, completion at edge N+1, xfer_done high after edge N+1.
- Back-to-back transfers (SETUP immediately after completion) are legal. No error is raised and xfer_done can pulse on consecutive transfers two cycles apart.
- Reset (preset low, asynchronous) forces:
  - state IDLE
  - all outputs 0, including err_count and first_err_code
  - the latch cleared
- A transfer interrupted by reset is dropped silently. Tracking resumes on the first SETUP sampled after preset rises.

## Test plan
- Write: psel=0x0004, paddr=0x100, pwdata=0xDEADBEEF, with pready=1 in the first ACCESS cycle -> single xfer_done; xfer_write=1, xfer_slave=2, xfer_data=0xDEADBEEF, xfer_waits=0; err_count=0.
- Read with 3 waits: prdata=0x12345678 and pslverr=1 at completion -> xfer_done after the 4th ACCESS sample; xfer_waits=3, xfer_slverr=1, xfer_data=0x12345678.
- Timeout, TIMEOUT_CYCLES=16: pready held low for 16 ACCESS cycles -> one err_valid with code 10; err_count=1; no xfer_done; the next SETUP is tracked normally.
- psel=0x0005 in SETUP -> code 6. In a separate transfer, change paddr 0x100->0x104 mid-ACCESS -> code 9. first_err_code=6, err_count=2.
- penable=X with has_checks=0 -> no err_valid. Same stimulus with has_checks=1 -> code 4. Assert clear_err together with a code-7 violation -> err_count=1, first_err_code=7.
- Drive preset low during ACCESS of a read -> all outputs 0 immediately and no xfer_done. After release, a write to 0x200 completes with xfer_addr=0x200.
